i2s_tx_scheduler: RTL and testbench

- Single-clock I2S transmit controller for the synthesizer audio output path.
- Buffers stereo sample pairs from the synth engine in a small FIFO and derives bclk from sclk.
- Schedules one left/right pair per frame, drives lrclk/sd in standard I2S format, and detects and counts underruns.
- Sits between the voice mixer (valid/ready source) and the DAC pins.

---
 rtl/i2s_tx_scheduler.sv | 172 +++++++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_scheduler.sv
// I2S transmitter: stereo-pair FIFO, bclk prescaler and frame shifter.
// Each frame loads on the falling bclk that starts bit 0; an empty FIFO at that point sends zeros and is counted.
module i2s_tx_scheduler #(
  parameter int DIV        = 16,
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_left,
  input  logic [WIDTH-1:0] s_right,
  output logic             bclk,
  output logic             lrclk,
  output logic             sd,
  output logic             busy,
  output logic [7:0]       underrun_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int PW = $clog2(DIV);
  localparam int FW = 2 * WIDTH;
  localparam int BW = $clog2(FW);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  logic [WIDTH-1:0] mem_l_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_r_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  state_e           state_q;
  logic [PW-1:0]    presc_q;
  logic [BW-1:0]    bit_q;
  logic [FW-2:0]    shift_q;
  logic             bclk_q;
  logic             lrclk_q;
  logic             sd_q;
  logic             busy_q;
  logic [7:0]       underrun_q;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             tick_s;
  logic             frame_start_s;
  logic [FW-1:0]    head_s;

  // FIFO flags, handshake, prescaler wrap detection and pointer next-state
  always_comb begin
    full_s        = (count_q == CW'(FIFO_DEPTH));
    empty_s       = (count_q == {CW{1'b0}});
    push_s        = s_valid && !full_s;
    tick_s        = (state_q == ST_RUN) && (presc_q == PW'(DIV - 1));
    frame_start_s = tick_s && bclk_q && (bit_q == {BW{1'b0}});
    pop_s         = frame_start_s && enable && !empty_s;
    head_s        = {mem_l_q[rd_ptr_q], mem_r_q[rd_ptr_q]};
    count_d       = count_q + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  assign s_ready        = !full_s;
  assign bclk           = bclk_q;
  assign lrclk          = lrclk_q;
  assign sd             = sd_q;
  assign busy           = busy_q;
  assign underrun_count = underrun_q;

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge sclk) begin
    if (push_s) begin
      mem_l_q[wr_ptr_q] <= s_left;
      mem_r_q[wr_ptr_q] <= s_right;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Control FSM, prescaler, bit sequencing and serial outputs
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= {PW{1'b0}};
      bit_q      <= {BW{1'b0}};
      shift_q    <= {(FW-1){1'b0}};
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      sd_q       <= 1'b0;
      busy_q     <= 1'b0;
      underrun_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_q <= {PW{1'b0}};
          bclk_q  <= 1'b0;
          if (enable) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!tick_s) begin
            presc_q <= presc_q + PW'(1);
          end else begin
            presc_q <= {PW{1'b0}};
            if (!bclk_q) begin
              bclk_q <= 1'b1;
            end else if (frame_start_s && !enable) begin
              // Frame boundary with run dropped: stop cleanly, leave the FIFO untouched
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              bclk_q  <= 1'b0;
              sd_q    <= 1'b0;
              lrclk_q <= 1'b0;
            end else begin
              bclk_q <= 1'b0;
              bit_q  <= (bit_q == BW'(FW - 1)) ? {BW{1'b0}} : bit_q + BW'(1);
              if (frame_start_s) begin
                shift_q <= empty_s ? {(FW-1){1'b0}} : head_s[FW-2:0];
                sd_q    <= empty_s ? 1'b0 : head_s[FW-1];
                if (empty_s && (underrun_q != 8'hFF)) begin
                  underrun_q <= underrun_q + 8'd1;
                end
              end else begin
                shift_q <= {shift_q[FW-3:0], 1'b0};
                sd_q    <= shift_q[FW-2];
              end
              // Word select leads the data by one bit
              if (bit_q == BW'(WIDTH - 1)) begin
                lrclk_q <= 1'b1;
              end else if (bit_q == BW'(FW - 1)) begin
                lrclk_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler at default parameters; bits are captured on rising bclk.
module tb_i2s_tx_scheduler;

  localparam int DIV = 16;
  localparam int WIDTH = 16;
  localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

  logic        sclk    = 1'b0;
  logic        rst     = 1'b1;
  logic        enable  = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_left  = 16'h0000;
  logic [15:0] s_right = 16'h0000;
  logic        s_ready;
  logic        bclk;
  logic        lrclk;
  logic        sd;
  logic        busy;
  logic [7:0]  underrun_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          c0 = 0;
  logic        prev_bclk = 1'b0;
  logic        bclk_seen = 1'b0;
  logic [31:0] cap_d = 32'd0;
  logic [31:0] cap_lr = 32'd0;

  logic [15:0] pl [5] = '{16'h1111, 16'h2468, 16'h8421, 16'hF00D, 16'h7E57};
  logic [15:0] pr [5] = '{16'hAAAA, 16'h1357, 16'h0001, 16'hCAFE, 16'h8001};

  i2s_tx_scheduler #(.DIV(DIV), .WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
    .sclk          (sclk),
    .rst           (rst),
    .enable        (enable),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_left        (s_left),
    .s_right       (s_right),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sd            (sd),
    .busy          (busy),
    .underrun_count(underrun_count)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    prev_bclk = bclk_seen;
    @(posedge sclk);
    #1;
    bclk_seen = bclk;
    cyc++;
  endtask

  task automatic wait_edge(input logic rising, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * DIV + 4 && !hit; i++) begin
      step();
      if (rising) hit = bclk_seen && !prev_bclk;
      else        hit = !bclk_seen && prev_bclk;
    end
    if (!hit) check({tag, "_timeout"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic capture_bits(input int n);
    for (int i = 0; i < n; i++) begin
      wait_edge(1'b1, "bit_rise");
      cap_d  = {cap_d[30:0], sd};
      cap_lr = {cap_lr[30:0], lrclk};
    end
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    s_valid = 1'b0;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    do_reset();
    step();
    check("reset_outs", {27'd0, bclk, lrclk, sd, busy, s_ready}, 32'h1);
    check("reset_urun", {24'd0, underrun_count}, 32'd0);

    // Basic frame and timing
    push(16'hA5F0, 16'h0F3C);
    enable = 1'b1;
    step();
    check("t1_busy", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 15) check("t1_pre_rise", {31'd0, bclk}, 32'd0);
      if (i == 16) check("t1_rise", {31'd0, bclk}, 32'd1);
      if (i == 31) check("t1_pre_fall", {31'd0, bclk}, 32'd1);
      if (i == 32) begin
        check("t1_fall", {31'd0, bclk}, 32'd0);
        check("t1_sd_msb", {31'd0, sd}, 32'd1);
        c0 = cyc;
      end
    end
    check("t1_urun", {24'd0, underrun_count}, 32'd0);
    capture_bits(32);
    check("t1_data", cap_d, 32'hA5F0_0F3C);
    check("t1_lrclk", cap_lr, LR_PATTERN);
    wait_edge(1'b0, "t1_fall2");
    check("t1_period", cyc - c0, 32'd1024);
    check("t1_urun_next", {24'd0, underrun_count}, 32'd1);
    do_reset();

    // Underrun frames, then a real pair
    enable = 1'b1;
    step();
    for (int f = 1; f <= 3; f++) begin
      wait_edge(1'b0, "t2_load");
      check("t2_urun", {24'd0, underrun_count}, f);
      check("t2_sd", {31'd0, sd}, 32'd0);
      if (f == 3) push(16'h8000, 16'h7FFF);
      capture_bits(32);
      check("t2_zero", cap_d, 32'd0);
    end
    wait_edge(1'b0, "t2_load4");
    check("t2_urun_hold", {24'd0, underrun_count}, 32'd3);
    capture_bits(32);
    check("t2_data", cap_d, 32'h8000_7FFF);
    do_reset();

    // FIFO full, back-pressure, ordering
    for (int i = 0; i < 4; i++) begin
      s_left  = pl[i];
      s_right = pr[i];
      s_valid = 1'b1;
      step();
    end
    check("t3_full", {31'd0, s_ready}, 32'd0);
    s_left  = pl[4];
    s_right = pr[4];
    step();
    step();
    check("t3_held", {31'd0, s_ready}, 32'd0);
    enable = 1'b1;
    step();
    wait_edge(1'b0, "t3_load1");
    check("t3_ready_pop", {31'd0, s_ready}, 32'd1);
    step();
    s_valid = 1'b0;
    check("t3_refull", {31'd0, s_ready}, 32'd0);
    capture_bits(32);
    check("t3_pair0", cap_d, {pl[0], pr[0]});
    for (int i = 1; i < 5; i++) begin
      wait_edge(1'b0, "t3_load");
      capture_bits(32);
      check("t3_pair", cap_d, {pl[i], pr[i]});
    end
    check("t3_urun", {24'd0, underrun_count}, 32'd0);
    do_reset();

    // Disable mid-frame
    push(16'hC3A5, 16'h5A5B);
    push(16'h0F0F, 16'hF0F0);
    enable = 1'b1;
    step();
    wait_edge(1'b0, "t4_load");
    capture_bits(11);
    enable = 1'b0;
    capture_bits(21);
    check("t4_data", cap_d, 32'hC3A5_5A5B);
    check("t4_lrclk", cap_lr, LR_PATTERN);
    wait_edge(1'b0, "t4_stop");
    check("t4_idle", {28'd0, bclk, lrclk, sd, busy}, 32'd0);
    for (int i = 0; i < 40; i++) step();
    check("t4_stays_idle", {30'd0, bclk, busy}, 32'd0);
    push(16'h0001, 16'h0002);
    push(16'h0003, 16'h0004);
    push(16'h0005, 16'h0006);
    check("t4_no_pop", {31'd0, s_ready}, 32'd0);
    do_reset();

    // Reset mid-frame
    push(16'h1234, 16'hFFFF);
    push(16'h5555, 16'h6666);
    push(16'h7777, 16'h9999);
    enable = 1'b1;
    step();
    wait_edge(1'b0, "t5_load");
    capture_bits(20);
    wait_edge(1'b0, "t5_b20");
    check("t5_pre", {30'd0, lrclk, sd}, 32'd3);
    rst = 1'b1;
    step();
    check("t5_rst_outs", {27'd0, bclk, lrclk, sd, busy, s_ready}, 32'h1);
    rst = 1'b0;
    step();
    wait_edge(1'b0, "t5_reload");
    check("t5_urun", {24'd0, underrun_count}, 32'd1);
    check("t5_sd", {31'd0, sd}, 32'd0);
    do_reset();

    // Push coinciding with the load of an empty FIFO
    enable = 1'b1;
    step();
    for (int i = 0; i < 31; i++) step();
    s_left  = 16'hBEEF;
    s_right = 16'h1357;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    check("t6_load_fall", {31'd0, bclk}, 32'd0);
    check("t6_urun", {24'd0, underrun_count}, 32'd1);
    capture_bits(32);
    check("t6_zero", cap_d, 32'd0);
    wait_edge(1'b0, "t6_load2");
    check("t6_urun_hold", {24'd0, underrun_count}, 32'd1);
    capture_bits(32);
    check("t6_data", cap_d, 32'hBEEF_1357);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
